seven_seg_display_arbiter: RTL and testbench

- Shares the single 8-digit seven-segment display between NUM_SRC requesters.
- Source 0 is a preemptive alert. The other sources are time-sliced round-robin.
- Drives the 27-bit binary value consumed by the display scan FSM, plus grant/status.
- Sits between the game/timer logic and the display driver. It is the only block allowed to choose what the display shows.

---
 rtl/seven_seg_display_arbiter_pkg.sv | 54 +++++
 rtl/seven_seg_display_arbiter_ms_tick_gen.sv | 30 +++
 rtl/seven_seg_display_arbiter.sv | 178 +++++++++++++++++
 tb/tb_seven_seg_display_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_display_arbiter_pkg.sv
// Purpose: shared types, constants and source-search helpers for the display arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package seven_seg_pkg;

    localparam int VALUE_W = 27;

    // Largest value the 8-digit BCD display can show.
    localparam logic [VALUE_W-1:0] DISPLAY_MAX = 27'd99_999_999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        ALERT  = 2'd2
    } state_t;

    // Result of a rotation search: found flag plus winning source index.
    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Successor of p inside the rotation ring 1..num_src-1 (source 0 never rotates).
    function automatic logic [1:0] rot_inc(input logic [1:0] p, input int num_src);
        return (int'(p) >= num_src - 1) ? 2'd1 : 2'(p + 2'd1);
    endfunction

    // First requesting rotating source at or after p, wrapping num_src-1 -> 1.
    // Walks the ring backwards so the lowest offset from p is written last and wins.
    function automatic pick_t next_req(input logic [3:0] req, input logic [1:0] p,
                                       input int num_src);
        pick_t r;
        int    start;
        int    s;
        r     = '0;
        s     = 0;
        start = (p == 2'd0) ? 1 : int'(p);
        for (int k = 2; k >= 0; k--) begin
            if (k < num_src - 1) begin
                s = 1 + ((start - 1 + k) % (num_src - 1));
                if (req[s[1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = s[1:0];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [VALUE_W-1:0] clamp_display(input logic [VALUE_W-1:0] v);
        return (v > DISPLAY_MAX) ? DISPLAY_MAX : v;
    endfunction

endpackage

// File: rtl/seven_seg_display_arbiter_ms_tick_gen.sv
// Purpose: free-running prescaler producing a one-cycle 1 ms enable strobe (not a clock).
// Latency: strobe asserted combinationally while the prescaler sits at CLK_PER_MS-1.
// Backpressure: none; free-runs from reset and is never re-phased.
// Ports: clock, reset (async active-high), ms_tick (enable strobe).
module ms_tick_gen #(
    parameter int CLK_PER_MS = 100000
) (
    input  logic clock,
    input  logic reset,
    output logic ms_tick
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_MS - 1);

    logic [PW-1:0] prescaler;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (prescaler == LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign ms_tick = (prescaler == LAST);

endmodule

// File: rtl/seven_seg_display_arbiter.sv
// Purpose: picks which requester owns the 8-digit display; source 0 preempts, others round-robin.
// Latency: request change -> state update next edge -> registered outputs one edge later.
// Backpressure: none; level requests, sources simply wait while not granted.
// Ports: clock, reset (async active-high), req[NUM_SRC], value_flat[27*NUM_SRC],
//        twentyseven_bit_number[27], grant[NUM_SRC] one-hot, active_src[2], idle.
module seven_seg_display_arbiter
    import seven_seg_pkg::*;
#(
    parameter int NUM_SRC       = 3,
    parameter int CLK_PER_MS    = 100000,
    parameter int DWELL_MS      = 2000,
    parameter int ALERT_HOLD_MS = 1000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [VALUE_W*NUM_SRC-1:0] value_flat,
    output logic [VALUE_W-1:0]         twentyseven_bit_number,
    output logic [NUM_SRC-1:0]         grant,
    output logic [1:0]                 active_src,
    output logic                       idle
);

    localparam int DW = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam int HW = (ALERT_HOLD_MS > 1) ? $clog2(ALERT_HOLD_MS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_MS - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(ALERT_HOLD_MS - 1);

    logic ms_tick;

    ms_tick_gen #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_ms_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .ms_tick(ms_tick)
    );

    state_t        state_q,   state_d;
    logic [1:0]    cur_q,     cur_d;
    logic [1:0]    rr_ptr_q,  rr_ptr_d;
    logic [1:0]    saved_q,   saved_d;
    logic [DW-1:0] dwell_q,   dwell_d;
    logic [HW-1:0] hold_q,    hold_d;

    // Requests padded to the widest supported configuration so the search helper is fixed-width.
    logic [3:0] req_pad;
    pick_t      pick;

    logic [VALUE_W-1:0] src_val [4];

    for (genvar g = 0; g < 4; g++) begin : g_src
        if (g < NUM_SRC) begin : g_used
            assign src_val[g] = value_flat[VALUE_W*g +: VALUE_W];
        end else begin : g_pad
            assign src_val[g] = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_q    <= 2'd0;
            rr_ptr_q <= 2'd1;
            saved_q  <= 2'd1;
            dwell_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            rr_ptr_q <= rr_ptr_d;
            saved_q  <= saved_d;
            dwell_q  <= dwell_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        rr_ptr_d = rr_ptr_q;
        saved_d  = saved_q;
        dwell_d  = dwell_q;
        hold_d   = hold_q;
        pick     = '0;
        req_pad  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req_pad[i] = req[i];
        end

        case (state_q)
            IDLE: begin
                if (req_pad[0]) begin
                    state_d = ALERT;
                    saved_d = rr_ptr_q;
                    cur_d   = 2'd0;
                    hold_d  = '0;
                end else begin
                    pick = next_req(req_pad, rr_ptr_q, NUM_SRC);
                    if (pick.found) begin
                        state_d = ROTATE;
                        cur_d   = pick.idx;
                        dwell_d = '0;
                    end
                end
            end

            ROTATE: begin
                if (req_pad[0]) begin
                    state_d = ALERT;
                    saved_d = cur_q;
                    cur_d   = 2'd0;
                    hold_d  = '0;
                end else if (!req_pad[cur_q] || (ms_tick && dwell_q == DWELL_LAST)) begin
                    // Drop and expiry together still produce a single hand-off.
                    // Searching from cur+1 lets a lone requester re-win its own slot.
                    pick    = next_req(req_pad, rot_inc(cur_q, NUM_SRC), NUM_SRC);
                    dwell_d = '0;
                    if (pick.found) begin
                        cur_d = pick.idx;
                    end else begin
                        state_d  = IDLE;
                        rr_ptr_d = rot_inc(cur_q, NUM_SRC);
                    end
                end else if (ms_tick) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end

            ALERT: begin
                if (req_pad[0]) begin
                    hold_d = '0;
                end else if (ms_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        // Resume the interrupted source if still asking, else whoever follows it.
                        pick    = next_req(req_pad, saved_q, NUM_SRC);
                        dwell_d = '0;
                        if (pick.found) begin
                            state_d = ROTATE;
                            cur_d   = pick.idx;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage samples the source value every cycle so the display follows live data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            twentyseven_bit_number <= '0;
            grant                  <= '0;
            active_src             <= 2'd0;
            idle                   <= 1'b1;
        end else if (state_q == IDLE) begin
            twentyseven_bit_number <= '0;
            grant                  <= '0;
            active_src             <= 2'd0;
            idle                   <= 1'b1;
        end else begin
            twentyseven_bit_number <= clamp_display(src_val[cur_q]);
            for (int i = 0; i < NUM_SRC; i++) begin
                grant[i] <= (cur_q == 2'(i));
            end
            active_src             <= cur_q;
            idle                   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Purpose: self-checking bench for the display arbiter against a time-sliced reference model.
// Latency: model predicts registered outputs one edge after its own state update.
// Backpressure: n/a.
module tb_seven_seg_display_arbiter;

    localparam int NS   = 3;
    localparam int CPM  = 4;
    localparam int DWM  = 3;
    localparam int AHM  = 2;
    localparam int MAXV = 99_999_999;
    localparam logic [32:0] IDLE_VEC = {1'b1, 3'b000, 2'd0, 27'd0};

    logic          clock = 1'b0;
    logic          reset;
    logic [NS-1:0] req;
    logic [26:0]   src_v [NS];
    logic [27*NS-1:0] value_flat;
    logic [26:0]   twentyseven_bit_number;
    logic [NS-1:0] grant;
    logic [1:0]    active_src;
    logic          idle;
    logic [32:0]   obs_vec;

    assign value_flat = {src_v[2], src_v[1], src_v[0]};
    assign obs_vec    = {idle, grant, active_src, twentyseven_bit_number};

    always #5 clock = ~clock;

    seven_seg_display_arbiter #(
        .NUM_SRC      (NS),
        .CLK_PER_MS   (CPM),
        .DWELL_MS     (DWM),
        .ALERT_HOLD_MS(AHM)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .req                   (req),
        .value_flat            (value_flat),
        .twentyseven_bit_number(twentyseven_bit_number),
        .grant                 (grant),
        .active_src            (active_src),
        .idle                  (idle)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 = nobody shown, 1 = rotating owner, 2 = alert owner.
    int m_mode, m_cur, m_ptr, m_saved, m_ticks, m_hold, m_cyc;
    logic [32:0] e_vec;

    function automatic int ring_after(int s);
        return (s >= NS - 1) ? 1 : s + 1;
    endfunction

    function automatic int find_next(int p);
        int s;
        for (int k = 0; k < NS - 1; k++) begin
            s = 1 + ((p - 1 + k) % (NS - 1));
            if (req[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cur = 0; m_ptr = 1; m_saved = 1;
        m_ticks = 0; m_hold = 0; m_cyc = 0;
        e_vec = IDLE_VEC;
    endtask

    task automatic model_edge();
        bit tick;
        int n;
        logic [26:0] v;
        if (reset) begin
            model_reset();
        end else begin
            tick = (m_cyc % CPM) == CPM - 1;
            if (m_mode == 0) begin
                e_vec = IDLE_VEC;
            end else begin
                v = src_v[m_cur];
                if (v > MAXV) v = 27'(MAXV);
                e_vec = {1'b0, 3'(1 << m_cur), 2'(m_cur), v};
            end
            if (m_mode == 0) begin
                if (req[0]) begin
                    m_mode = 2; m_saved = m_ptr; m_cur = 0; m_hold = 0;
                end else begin
                    n = find_next(m_ptr);
                    if (n >= 0) begin m_mode = 1; m_cur = n; m_ticks = 0; end
                end
            end else if (m_mode == 1) begin
                if (req[0]) begin
                    m_mode = 2; m_saved = m_cur; m_cur = 0; m_hold = 0;
                end else if (!req[m_cur] || (tick && m_ticks + 1 == DWM)) begin
                    n = find_next(ring_after(m_cur));
                    m_ticks = 0;
                    if (n < 0) begin m_mode = 0; m_ptr = ring_after(m_cur); end
                    else m_cur = n;
                end else if (tick) begin
                    m_ticks++;
                end
            end else begin
                if (req[0]) begin
                    m_hold = 0;
                end else if (tick) begin
                    if (m_hold + 1 == AHM) begin
                        n = find_next(m_saved);
                        m_ticks = 0;
                        if (n < 0) m_mode = 0;
                        else begin m_mode = 1; m_cur = n; end
                    end else begin
                        m_hold++;
                    end
                end
            end
            m_cyc++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0;
        for (int i = 0; i < NS; i++) src_v[i] = '0;
        repeat (3) step();
        n_cmp++;
        if (obs_vec !== IDLE_VEC) begin n_bad++; $display("FAIL reset_initial got %h want %h", obs_vec, IDLE_VEC); end
        reset = 1'b0;
        repeat (6) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL reset_idle got %h want %h", obs_vec, e_vec); end
        end
        req = 3'b110; src_v[1] = 27'd11; src_v[2] = 27'd22;
        repeat (7) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL reset_busy got %h want %h", obs_vec, e_vec); end
        end
        n_cmp++;
        if (idle !== 1'b0) begin n_bad++; $display("FAIL reset_pre_busy got idle=%b want 0", idle); end
        reset = 1'b1; req = '0;
        #1;
        n_cmp++;
        if (obs_vec !== IDLE_VEC) begin n_bad++; $display("FAIL reset_async got %h want %h", obs_vec, IDLE_VEC); end
        repeat (3) begin
            step(); n_cmp++;
            if (obs_vec !== IDLE_VEC) begin n_bad++; $display("FAIL reset_held got %h want %h", obs_vec, IDLE_VEC); end
        end
        reset = 1'b0;
    endtask

    task automatic test_rotation();
        do_reset();
        src_v[0] = 27'd42; src_v[1] = 27'd1234; src_v[2] = 27'd5678; req = 3'b110;
        for (int k = 1; k <= 30; k++) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL rotation got %h want %h", obs_vec, e_vec); end
            if (k == 2 || k == 25) begin
                n_cmp++;
                if (grant !== 3'b010 || twentyseven_bit_number !== 27'd1234) begin
                    n_bad++; $display("FAIL rotation_src1 step %0d got grant=%b val=%0d want 010/1234", k, grant, twentyseven_bit_number);
                end
            end
            if (k == 13) begin
                n_cmp++;
                if (grant !== 3'b100 || twentyseven_bit_number !== 27'd5678) begin
                    n_bad++; $display("FAIL rotation_src2 got grant=%b val=%0d want 100/5678", grant, twentyseven_bit_number);
                end
            end
        end
    endtask

    task automatic test_preempt();
        int cnt;
        bit done;
        do_reset();
        src_v[0] = 27'd42; src_v[1] = 27'd1234; src_v[2] = 27'd5678; req = 3'b110;
        repeat (14) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL preempt_pre got %h want %h", obs_vec, e_vec); end
        end
        req = 3'b111;
        repeat (2) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL preempt_model got %h want %h", obs_vec, e_vec); end
        end
        n_cmp++;
        if (twentyseven_bit_number !== 27'd42 || grant !== 3'b001) begin
            n_bad++; $display("FAIL preempt_latency got grant=%b val=%0d want 001/42", grant, twentyseven_bit_number);
        end
        repeat (2) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL preempt_hold got %h want %h", obs_vec, e_vec); end
        end
        req = 3'b110;
        cnt = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL alert_tail got %h want %h", obs_vec, e_vec); end
            if (grant == 3'b001) cnt++; else done = 1;
        end
        n_cmp++;
        if (!done || cnt < CPM + 1 || cnt > AHM * CPM) begin
            n_bad++; $display("FAIL alert_hold_len got %0d cycles (ended=%0d) want %0d..%0d", cnt, done, CPM + 1, AHM * CPM);
        end
        n_cmp++;
        if (grant !== 3'b100 || twentyseven_bit_number !== 27'd5678) begin
            n_bad++; $display("FAIL resume_src2 got grant=%b val=%0d want 100/5678", grant, twentyseven_bit_number);
        end
        cnt = 1; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL resume_model got %h want %h", obs_vec, e_vec); end
            if (grant == 3'b100) cnt++; else done = 1;
        end
        n_cmp++;
        if (!done || cnt != DWM * CPM) begin
            n_bad++; $display("FAIL resume_dwell got %0d cycles want %0d", cnt, DWM * CPM);
        end
    endtask

    task automatic test_drop_clamp();
        do_reset();
        src_v[0] = 27'd42; src_v[1] = 27'd1234; src_v[2] = 27'h7FF_FFFF; req = 3'b110;
        repeat (5) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL drop_pre got %h want %h", obs_vec, e_vec); end
        end
        req = 3'b100;
        repeat (2) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL drop_model got %h want %h", obs_vec, e_vec); end
        end
        n_cmp++;
        if (grant !== 3'b100 || twentyseven_bit_number !== 27'd99_999_999) begin
            n_bad++; $display("FAIL drop_clamp got grant=%b val=%0d want 100/99999999", grant, twentyseven_bit_number);
        end
        src_v[2] = 27'd100_000_000;
        step(); n_cmp++;
        if (twentyseven_bit_number !== 27'd99_999_999) begin
            n_bad++; $display("FAIL clamp_edge_over got %0d want 99999999", twentyseven_bit_number);
        end
        src_v[2] = 27'd99_999_998;
        step(); n_cmp++;
        if (twentyseven_bit_number !== 27'd99_999_998) begin
            n_bad++; $display("FAIL clamp_edge_under got %0d want 99999998", twentyseven_bit_number);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        src_v[0] = 27'd42; src_v[1] = 27'd1234; src_v[2] = 27'd5678; req = 3'b110;
        repeat (11) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL simul_pre got %h want %h", obs_vec, e_vec); end
        end
        req = 3'b100;
        repeat (2) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL simul_model got %h want %h", obs_vec, e_vec); end
        end
        n_cmp++;
        if (grant !== 3'b100 || twentyseven_bit_number !== 27'd5678) begin
            n_bad++; $display("FAIL simul_single_advance got grant=%b val=%0d want 100/5678", grant, twentyseven_bit_number);
        end
        req = 3'b011;
        repeat (3) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL simul_alert got %h want %h", obs_vec, e_vec); end
        end
        req = 3'b001;
        repeat (12) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL simul_empty got %h want %h", obs_vec, e_vec); end
        end
        n_cmp++;
        if (grant !== 3'b001 || twentyseven_bit_number !== 27'd42) begin
            n_bad++; $display("FAIL alert_stays got grant=%b val=%0d want 001/42", grant, twentyseven_bit_number);
        end
        req = 3'b000;
        repeat (20) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL simul_release got %h want %h", obs_vec, e_vec); end
        end
        n_cmp++;
        if (obs_vec !== IDLE_VEC) begin n_bad++; $display("FAIL alert_to_idle got %h want %h", obs_vec, IDLE_VEC); end
    endtask

    task automatic test_lone();
        do_reset();
        src_v[0] = 27'd42; src_v[1] = 27'd777; src_v[2] = 27'd5678; req = 3'b010;
        for (int k = 1; k <= 42; k++) begin
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL lone_model got %h want %h", obs_vec, e_vec); end
            if (k >= 2) begin
                n_cmp++;
                if (grant !== 3'b010 || twentyseven_bit_number !== 27'd777) begin
                    n_bad++; $display("FAIL lone_hold step %0d got grant=%b val=%0d want 010/777", k, grant, twentyseven_bit_number);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        req = '0;
        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                req[0] = ($urandom_range(0, 4) == 0);
                req[1] = 1'($urandom_range(0, 1));
                req[2] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 15) == 0) begin
                src_v[$urandom_range(0, NS - 1)] = ($urandom_range(0, 3) == 0)
                    ? 27'($urandom) : 27'($urandom_range(0, MAXV));
            end
            reset = ($urandom_range(0, 299) == 0);
            step(); n_cmp++;
            if (obs_vec !== e_vec) begin n_bad++; $display("FAIL random step %0d got %h want %h", k, obs_vec, e_vec); end
        end
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_preempt();
        test_drop_clamp();
        test_simultaneous();
        test_lone();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
